// File: rtl/from_rx_axis.sv
// from_rx_axis: buffers one frame from the MAC RX AXI-Stream, then replays it
// as a size word followed by payload words on a valid/yumi stream.
module from_rx_axis #(
    parameter int axis_data_width_p  = 64,
    parameter int max_frame_words_p  = 192,
    parameter int drop_count_width_p = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [axis_data_width_p-1:0]    rx_axis_tdata_i,
    input  logic [axis_data_width_p/8-1:0]  rx_axis_tkeep_i,
    input  logic                            rx_axis_tvalid_i,
    output logic                            rx_axis_tready_o,
    input  logic                            rx_axis_tlast_i,
    input  logic                            rx_axis_tuser_i,
    output logic [axis_data_width_p-1:0]    frame_data_o,
    output logic                            frame_data_v_o,
    input  logic                            frame_data_yumi_i,
    output logic [1:0]                      rx_ext_state_o,
    output logic [drop_count_width_p-1:0]   rx_drop_count_o
);

    localparam int keep_width_lp = axis_data_width_p / 8;
    localparam int ptr_width_lp  = $clog2(max_frame_words_p + 1);
    localparam logic [ptr_width_lp-1:0] max_words_lp = ptr_width_lp'(max_frame_words_p);
    localparam logic [ptr_width_lp-1:0] ptr_one_lp   = ptr_width_lp'(1);

    typedef enum logic [1:0] {
        RECV    = 2'b00,
        SIZE    = 2'b01,
        PAYLOAD = 2'b10
    } state_e;

    state_e state, state_next;

    logic [axis_data_width_p-1:0] buffer [max_frame_words_p];

    logic [ptr_width_lp-1:0]       wr_ptr, rd_ptr, nwords_r;
    logic                          ovf_r;
    logic [15:0]                   size_r;
    logic [drop_count_width_p-1:0] drop_count;

    logic        beat_accept;
    logic        beat_fits;
    logic        frame_bad;
    logic        drain_done;
    logic [3:0]  last_bytes;
    logic [15:0] frame_size;

    // Byte count of the last beat comes from the highest enabled lane only.
    always_comb begin
        last_bytes = 4'd0;
        for (int i = 0; i < keep_width_lp; i++) begin
            if (rx_axis_tkeep_i[i]) last_bytes = 4'(i + 1);
        end
    end

    assign beat_accept = rx_axis_tvalid_i & (state == RECV);
    assign beat_fits   = (wr_ptr < max_words_lp);
    assign frame_size  = 16'({wr_ptr, 3'b000}) + 16'(last_bytes);
    assign frame_bad   = rx_axis_tuser_i | ovf_r | ~beat_fits | (frame_size == 16'd0);
    assign drain_done  = (state == PAYLOAD) & frame_data_yumi_i & (rd_ptr == nwords_r - ptr_one_lp);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= RECV;
        else         state <= state_next;
    end

    always_comb begin
        state_next       = state;
        rx_axis_tready_o = 1'b0;
        frame_data_v_o   = 1'b0;
        frame_data_o     = buffer[rd_ptr];
        case (state)
            RECV: begin
                rx_axis_tready_o = 1'b1;
                if (rx_axis_tvalid_i && rx_axis_tlast_i && !frame_bad) state_next = SIZE;
            end
            SIZE: begin
                frame_data_v_o = 1'b1;
                frame_data_o   = {{(axis_data_width_p-16){1'b0}}, size_r};
                if (frame_data_yumi_i) state_next = PAYLOAD;
            end
            PAYLOAD: begin
                frame_data_v_o = 1'b1;
                if (drain_done) state_next = RECV;
            end
            default: state_next = RECV;
        endcase
    end

    // Pointers clear on every tlast so a dropped frame leaves no residue.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            nwords_r   <= '0;
            ovf_r      <= 1'b0;
            size_r     <= '0;
            drop_count <= '0;
        end else begin
            if (beat_accept) begin
                if (rx_axis_tlast_i) begin
                    wr_ptr <= '0;
                    ovf_r  <= 1'b0;
                    if (frame_bad) begin
                        drop_count <= drop_count + drop_count_width_p'(1);
                    end else begin
                        size_r   <= frame_size;
                        nwords_r <= wr_ptr + ptr_one_lp;
                    end
                end else if (beat_fits) begin
                    wr_ptr <= wr_ptr + ptr_one_lp;
                end else begin
                    ovf_r <= 1'b1;
                end
            end
            if (state == SIZE && frame_data_yumi_i)         rd_ptr <= '0;
            else if (state == PAYLOAD && frame_data_yumi_i) rd_ptr <= rd_ptr + ptr_one_lp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (beat_accept && beat_fits) buffer[wr_ptr] <= rx_axis_tdata_i;
    end

    assign rx_ext_state_o  = state;
    assign rx_drop_count_o = drop_count;

endmodule

// File: tb/tb_from_rx_axis.sv
// Randomized self-checking bench for from_rx_axis; the model is a queue of
// beat words plus the frame-size and discard rules.
module tb_from_rx_axis;

    localparam int MAXW = 192;
    localparam int DCW  = 16;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [63:0]    rx_axis_tdata_i;
    logic [7:0]     rx_axis_tkeep_i;
    logic           rx_axis_tvalid_i;
    logic           rx_axis_tready_o;
    logic           rx_axis_tlast_i;
    logic           rx_axis_tuser_i;
    logic [63:0]    frame_data_o;
    logic           frame_data_v_o;
    logic           frame_data_yumi_i;
    logic [1:0]     rx_ext_state_o;
    logic [DCW-1:0] rx_drop_count_o;

    from_rx_axis #(
        .axis_data_width_p (64),
        .max_frame_words_p (MAXW),
        .drop_count_width_p(DCW)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .rx_axis_tdata_i  (rx_axis_tdata_i),
        .rx_axis_tkeep_i  (rx_axis_tkeep_i),
        .rx_axis_tvalid_i (rx_axis_tvalid_i),
        .rx_axis_tready_o (rx_axis_tready_o),
        .rx_axis_tlast_i  (rx_axis_tlast_i),
        .rx_axis_tuser_i  (rx_axis_tuser_i),
        .frame_data_o     (frame_data_o),
        .frame_data_v_o   (frame_data_v_o),
        .frame_data_yumi_i(frame_data_yumi_i),
        .rx_ext_state_o   (rx_ext_state_o),
        .rx_drop_count_o  (rx_drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;
    int exp_drops  = 0;
    logic [63:0] words[$];

    // Frame bytes in the last beat: position of the highest enabled lane.
    function automatic int keep_bytes(input logic [7:0] k);
        for (int i = 7; i >= 0; i--) begin
            if (k[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic fill_random(input int nb);
        words.delete();
        for (int i = 0; i < nb; i++) words.push_back({$urandom, $urandom});
    endtask

    task automatic fill_counting(input int nb);
        logic [63:0] w;
        words.delete();
        for (int i = 0; i < nb; i++) begin
            for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(i*8 + b);
            words.push_back(w);
        end
    endtask

    // Starts and ends at a negedge; junk tkeep/tuser on non-last beats.
    task automatic send_frame(input logic [7:0] last_keep, input logic bad, input bit gaps);
        bit is_last;
        for (int i = 0; i < words.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    rx_axis_tvalid_i = 1'b0;
                    @(posedge clk_i);
                    @(negedge clk_i);
                end
            end
            is_last          = (i == words.size() - 1);
            rx_axis_tvalid_i = 1'b1;
            rx_axis_tdata_i  = words[i];
            rx_axis_tlast_i  = is_last;
            rx_axis_tkeep_i  = is_last ? last_keep : 8'($urandom);
            rx_axis_tuser_i  = is_last ? bad : 1'($urandom);
            compared++;
            if (rx_axis_tready_o !== 1'b1) begin
                $display("[TB] FAIL tready_recv beat %0d: got %b expected 1", i, rx_axis_tready_o);
                mismatched++;
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        rx_axis_tvalid_i = 1'b0;
        rx_axis_tlast_i  = 1'b0;
        rx_axis_tuser_i  = 1'b0;
    endtask

    task automatic drain_frame(input int exp_size, input int stall_mode);
        int          idx    = -1;
        int          budget = 20000;
        logic [63:0] exp_word;
        logic [1:0]  exp_state;
        logic        yumi;
        while (idx < words.size() && budget > 0) begin
            exp_word  = (idx < 0) ? 64'(exp_size) : words[idx];
            exp_state = (idx < 0) ? 2'b01 : 2'b10;
            compared += 4;
            if (frame_data_v_o !== 1'b1) begin
                $display("[TB] FAIL drain_valid word %0d: got %b expected 1", idx, frame_data_v_o);
                mismatched++;
            end
            if (frame_data_o !== exp_word) begin
                $display("[TB] FAIL drain_data word %0d: got %h expected %h", idx, frame_data_o, exp_word);
                mismatched++;
            end
            if (rx_ext_state_o !== exp_state) begin
                $display("[TB] FAIL drain_state word %0d: got %b expected %b", idx, rx_ext_state_o, exp_state);
                mismatched++;
            end
            if (rx_axis_tready_o !== 1'b0) begin
                $display("[TB] FAIL drain_tready word %0d: got %b expected 0", idx, rx_axis_tready_o);
                mismatched++;
            end
            case (stall_mode)
                0:       yumi = 1'b1;
                1:       yumi = 1'($urandom_range(0, 1));
                default: yumi = ($urandom_range(0, 15) == 0);
            endcase
            frame_data_yumi_i = yumi;
            @(posedge clk_i);
            if (yumi) idx++;
            @(negedge clk_i);
            frame_data_yumi_i = 1'b0;
            budget--;
        end
        if (budget == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d words expected %0d", idx, words.size());
        end
        compared += 3;
        if (frame_data_v_o !== 1'b0) begin
            $display("[TB] FAIL post_drain_valid: got %b expected 0", frame_data_v_o);
            mismatched++;
        end
        if (rx_ext_state_o !== 2'b00) begin
            $display("[TB] FAIL post_drain_state: got %b expected 00", rx_ext_state_o);
            mismatched++;
        end
        if (rx_axis_tready_o !== 1'b1) begin
            $display("[TB] FAIL post_drain_tready: got %b expected 1", rx_axis_tready_o);
            mismatched++;
        end
    endtask

    // Decides delivery or discard from the frame rules, then checks the outcome.
    task automatic run_frame(input logic [7:0] last_keep, input logic bad, input bit gaps, input int stall_mode);
        int nb       = words.size();
        int exp_size = (nb - 1) * 8 + keep_bytes(last_keep);
        bit drop     = bad || (nb > MAXW) || (exp_size == 0);
        send_frame(last_keep, bad, gaps);
        if (drop) begin
            exp_drops++;
            compared += 3;
            if (frame_data_v_o !== 1'b0) begin
                $display("[TB] FAIL drop_valid: got %b expected 0", frame_data_v_o);
                mismatched++;
            end
            if (rx_axis_tready_o !== 1'b1) begin
                $display("[TB] FAIL drop_tready: got %b expected 1", rx_axis_tready_o);
                mismatched++;
            end
            if (rx_drop_count_o !== DCW'(exp_drops)) begin
                $display("[TB] FAIL drop_count: got %0d expected %0d", rx_drop_count_o, exp_drops);
                mismatched++;
            end
        end else begin
            drain_frame(exp_size, stall_mode);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        @(negedge clk_i);
        compared += 4;
        if (rx_axis_tready_o !== 1'b1) begin
            $display("[TB] FAIL reset_tready: got %b expected 1", rx_axis_tready_o);
            mismatched++;
        end
        if (frame_data_v_o !== 1'b0) begin
            $display("[TB] FAIL reset_valid: got %b expected 0", frame_data_v_o);
            mismatched++;
        end
        if (rx_ext_state_o !== 2'b00) begin
            $display("[TB] FAIL reset_state: got %b expected 00", rx_ext_state_o);
            mismatched++;
        end
        if (rx_drop_count_o !== '0) begin
            $display("[TB] FAIL reset_drops: got %0d expected 0", rx_drop_count_o);
            mismatched++;
        end
        reset_i   = 1'b0;
        exp_drops = 0;
        @(negedge clk_i);
    endtask

    task automatic test_frame_60();
        fill_counting(8);
        run_frame(8'h0F, 1'b0, 1'b0, 0);
        compared++;
        if (rx_drop_count_o !== '0) begin
            $display("[TB] FAIL frame60_drops: got %0d expected 0", rx_drop_count_o);
            mismatched++;
        end
    endtask

    task automatic test_frame_64_and_1();
        fill_random(8);
        run_frame(8'hFF, 1'b0, 1'b0, 0);
        fill_random(1);
        run_frame(8'h01, 1'b0, 1'b0, 0);
        fill_random(2);
        run_frame(8'h81, 1'b0, 1'b0, 1);
    endtask

    task automatic test_bad_tuser();
        fill_random(8);
        run_frame(8'hFF, 1'b1, 1'b0, 0);
        fill_random(5);
        run_frame(8'h3F, 1'b0, 1'b0, 0);
        fill_random(1);
        run_frame(8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic test_oversize();
        fill_random(MAXW + 1);
        run_frame(8'hFF, 1'b0, 1'b0, 0);
        fill_random(MAXW);
        run_frame(8'hFF, 1'b0, 1'b0, 1);
    endtask

    task automatic test_back_to_back_random();
        for (int f = 0; f < 14; f++) begin
            int         nb   = $urandom_range(1, 20);
            logic [7:0] keep = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            logic       bad  = ($urandom_range(0, 5) == 0);
            fill_random(nb);
            run_frame(keep, bad, 1'($urandom), (f % 3 == 0) ? 2 : 1);
        end
    endtask

    task automatic test_reset_mid_payload();
        fill_random(6);
        send_frame(8'hFF, 1'b0, 1'b0);
        frame_data_yumi_i = 1'b1;
        repeat (4) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
        frame_data_yumi_i = 1'b0;
        compared++;
        if (frame_data_o !== words[3]) begin
            $display("[TB] FAIL pre_reset_word3: got %h expected %h", frame_data_o, words[3]);
            mismatched++;
        end
        reset_i = 1'b1;
        #1;
        compared += 4;
        if (frame_data_v_o !== 1'b0) begin
            $display("[TB] FAIL midreset_valid: got %b expected 0", frame_data_v_o);
            mismatched++;
        end
        if (rx_axis_tready_o !== 1'b1) begin
            $display("[TB] FAIL midreset_tready: got %b expected 1", rx_axis_tready_o);
            mismatched++;
        end
        if (rx_ext_state_o !== 2'b00) begin
            $display("[TB] FAIL midreset_state: got %b expected 00", rx_ext_state_o);
            mismatched++;
        end
        if (rx_drop_count_o !== '0) begin
            $display("[TB] FAIL midreset_drops: got %0d expected 0", rx_drop_count_o);
            mismatched++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i   = 1'b0;
        exp_drops = 0;
        fill_random(7);
        run_frame(8'h07, 1'b0, 1'b0, 1);
    endtask

    initial begin
        reset_i           = 1'b1;
        rx_axis_tdata_i   = '0;
        rx_axis_tkeep_i   = '0;
        rx_axis_tvalid_i  = 1'b0;
        rx_axis_tlast_i   = 1'b0;
        rx_axis_tuser_i   = 1'b0;
        frame_data_yumi_i = 1'b0;
        test_reset();
        test_frame_60();
        test_frame_64_and_1();
        test_bad_tuser();
        test_oversize();
        test_back_to_back_random();
        test_reset_mid_payload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
